// File: rtl/sram_pkg.sv
// Shared constants and FSM state type for the serial SRAM controller.
package sram_pkg;

    localparam int SRAM_ADDR_W = 24;
    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_CMD_W  = 8;
    localparam int FRAME_W     = SRAM_CMD_W + SRAM_ADDR_W + SRAM_DATA_W;

    localparam logic [SRAM_CMD_W-1:0] CMD_READ  = 8'h03;
    localparam logic [SRAM_CMD_W-1:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        RESP
    } state_t;

endpackage

// File: rtl/spi_sram_ctrl.sv
// SPI mode-0 master issuing one 48-SCK read or write frame per request to an external serial SRAM.
// Request handshake: a request is taken on the clk edge where req_valid && req_ready are both high.
module spi_sram_ctrl
    import sram_pkg::*;
#(
    parameter int RAM_NSCK   = 48,
    parameter int RAM_CS_LEN = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [SRAM_ADDR_W-1:0] req_addr,
    input  logic [SRAM_DATA_W-1:0] req_wdata,
    output logic                   rsp_valid,
    output logic [SRAM_DATA_W-1:0] rsp_rdata,
    output logic                   busy,
    output logic                   sck,
    output logic                   css,
    output logic                   sdo,
    input  logic                   sdi
);

    localparam int CNT_W = $clog2(2 * RAM_NSCK);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(2 * RAM_NSCK - 1);
    localparam logic [CNT_W-1:0] CS_LAST    = CNT_W'(RAM_CS_LEN - 1);

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [FRAME_W-1:0]     frame, frame_d;
    logic [SRAM_DATA_W-1:0] rx, rx_d;
    logic [SRAM_DATA_W-1:0] rsp_rdata_d;
    logic                   we, we_d;
    logic                   sck_d, css_d, sdo_d;
    logic                   rsp_valid_d, req_ready_d, busy_d;

    // Every output is computed for the next cycle and registered, so the pins never glitch.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        frame_d     = frame;
        rx_d        = rx;
        we_d        = we;
        sck_d       = 1'b0;
        css_d       = 1'b1;
        sdo_d       = sdo;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    frame_d = {req_we ? CMD_WRITE : CMD_READ, req_addr,
                               req_we ? req_wdata : {SRAM_DATA_W{1'b0}}};
                    sdo_d   = frame_d[FRAME_W-1];
                    css_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                css_d = 1'b0;
                if (cnt == CS_LAST) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SHIFT: begin
                css_d = 1'b0;
                cnt_d = cnt + 1'b1;
                // Rising SCK samples MISO; falling SCK presents the next MOSI bit.
                if (!sck) begin
                    sck_d = 1'b1;
                    rx_d  = {rx[SRAM_DATA_W-2:0], sdi};
                end else begin
                    frame_d = frame << 1;
                    sdo_d   = frame[FRAME_W-2];
                end
                if (cnt == SHIFT_LAST) begin
                    cnt_d   = '0;
                    state_d = TRAIL;
                end
            end
            TRAIL: begin
                css_d = 1'b0;
                if (cnt == CS_LAST) begin
                    cnt_d   = '0;
                    css_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = we ? {SRAM_DATA_W{1'b0}} : rx;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            frame     <= '0;
            rx        <= '0;
            we        <= 1'b0;
            sck       <= 1'b0;
            css       <= 1'b1;
            sdo       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            frame     <= frame_d;
            rx        <= rx_d;
            we        <= we_d;
            sck       <= sck_d;
            css       <= css_d;
            sdo       <= sdo_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            req_ready <= req_ready_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Bench for spi_sram_ctrl: a behavioural serial SRAM on the SPI pins plus a word-level reference memory.
module tb_spi_sram_ctrl;
    import sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic        sck;
    logic        css;
    logic        sdo;
    logic        sdi = 1'b0;

    spi_sram_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .sck       (sck),
        .css       (css),
        .sdo       (sdo),
        .sdi       (sdi)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Serial SRAM model and pin monitors
    logic [47:0] cap = '0;
    int          nrise = 0;
    int          css_low = 0;
    int          rsp_cnt = 0;
    int          ready_bad = 0;
    int          acc_cnt = 0;
    time         acc_t = 0;
    logic        force_ones = 1'b0;
    logic [15:0] rd_word = '0;
    logic [15:0] sram_mem [logic [23:0]];
    logic [15:0] ref_mem [logic [23:0]];

    function automatic logic [15:0] dflt(input logic [23:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    always @(negedge css) begin
        acc_t   = $time;
        acc_cnt++;
        nrise   = 0;
        css_low = 0;
        cap     = '0;
    end

    always @(posedge sck) begin
        if (!css) begin
            cap = {cap[46:0], sdo};
            nrise++;
        end
    end

    always @(posedge css) begin
        if (nrise == 48 && cap[47:40] == CMD_WRITE) sram_mem[cap[39:16]] = cap[15:0];
    end

    always @(negedge clk) begin
        if (force_ones) begin
            sdi = 1'b1;
        end else if (!css && !sck) begin
            if (nrise == 32)
                rd_word = sram_mem.exists(cap[23:0]) ? sram_mem[cap[23:0]] : dflt(cap[23:0]);
            if (nrise >= 32 && nrise < 48) sdi = rd_word[47 - nrise];
            else sdi = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (!css) css_low++;
        if (rsp_valid) rsp_cnt++;
        if (busy && req_ready) ready_bad++;
    end

    // scoreboard
    logic [15:0] exp_q[$];
    logic [47:0] exp_frame = '0;
    time         t_acc = 0;

    function automatic void expect_req(input logic we, input logic [23:0] addr, input logic [15:0] wdata);
        exp_frame = {we ? CMD_WRITE : CMD_READ, addr, we ? wdata : 16'h0000};
        if (we) begin
            exp_q.push_back(16'h0000);
            ref_mem[addr] = wdata;
        end else if (force_ones) begin
            exp_q.push_back(16'hFFFF);
        end else begin
            exp_q.push_back(ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr));
        end
    endfunction

    // driver tasks; both are entered and left on a falling clk edge
    task automatic start_req(input logic we, input logic [23:0] addr, input logic [15:0] wdata,
                             input bit keep);
        int waited = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", 48'(waited < 300), 48'd1);
        @(posedge clk);
        t_acc = $time;
        #1;
        expect_req(we, addr, wdata);
        if (!keep) begin
            req_valid = 1'b0;
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 24'($urandom);
            req_wdata = 16'($urandom);
        end
    endtask

    task automatic finish_req(input string tag);
        int          waited = 0;
        logic [15:0] exp_data;
        @(negedge clk);
        while (!rsp_valid && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_rsp_seen"}, 48'(waited < 300), 48'd1);
        check({tag, "_latency"}, 48'(($time - 5 - t_acc) / 10), 48'd101);
        check({tag, "_sck_pulses"}, 48'(nrise), 48'd48);
        check({tag, "_css_low"}, 48'(css_low), 48'd100);
        check({tag, "_frame"}, cap, exp_frame);
        exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
        check({tag, "_rdata"}, 48'(rsp_rdata), 48'(exp_data));
        check({tag, "_css_high"}, 48'(css), 48'd1);
        @(negedge clk);
        check({tag, "_rsp_one_cycle"}, 48'(rsp_valid), 48'd0);
    endtask

    int snap_rsp;
    int snap_acc;
    int waited;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req_ready", 48'(req_ready), 48'd0);
        check("rst_rsp_valid", 48'(rsp_valid), 48'd0);
        check("rst_rsp_rdata", 48'(rsp_rdata), 48'd0);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_sck", 48'(sck), 48'd0);
        check("rst_css", 48'(css), 48'd1);
        check("rst_sdo", 48'(sdo), 48'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 48'(req_ready), 48'd1);

        // directed write, then directed read from a preloaded location
        start_req(1'b1, 24'h01001C, 16'hA5C3, 1'b0);
        finish_req("wr");
        sram_mem[24'h000000] = 16'h1234;
        ref_mem[24'h000000]  = 16'h1234;
        start_req(1'b0, 24'h000000, 16'h0000, 1'b0);
        finish_req("rd");

        // MISO stuck high
        force_ones = 1'b1;
        start_req(1'b0, 24'h000123, 16'h0000, 1'b0);
        finish_req("rd_ones");
        force_ones = 1'b0;
        @(negedge clk);

        // back-to-back with req_valid held high across the first frame
        start_req(1'b0, 24'h01001C, 16'h0000, 1'b1);
        snap_acc = acc_cnt;
        finish_req("b2b1");
        check("b2b_second_accept", 48'(acc_cnt - snap_acc), 48'd1);
        check("b2b_spacing", 48'((acc_t - t_acc) / 10), 48'd102);
        t_acc = acc_t;
        expect_req(1'b0, 24'h01001C, 16'h0000);
        req_valid = 1'b0;
        finish_req("b2b2");

        // request pulsed mid-frame must be ignored
        start_req(1'b1, 24'h000040, 16'h0F0F, 1'b0);
        repeat (30) @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 24'h000077;
        req_wdata = 16'hBEEF;
        check("shift_ready_low", 48'(req_ready), 48'd0);
        @(negedge clk);
        req_valid = 1'b0;
        finish_req("pulse");
        snap_rsp = rsp_cnt;
        snap_acc = acc_cnt;
        repeat (120) @(negedge clk);
        check("pulse_no_frame", 48'(acc_cnt - snap_acc), 48'd0);
        check("pulse_no_rsp", 48'(rsp_cnt - snap_rsp), 48'd0);

        // reset in the middle of the shift phase
        start_req(1'b0, 24'h000040, 16'h0000, 1'b0);
        waited = 0;
        while (nrise < 20 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("abort_reached_bit20", 48'(nrise), 48'd20);
        snap_rsp = rsp_cnt;
        rst = 1'b1;
        #1;
        check("abort_css", 48'(css), 48'd1);
        check("abort_sck", 48'(sck), 48'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        check("abort_no_rsp", 48'(rsp_cnt - snap_rsp), 48'd0);
        start_req(1'b1, 24'h00ABCD, 16'h5AA5, 1'b0);
        finish_req("post_abort");
        start_req(1'b0, 24'h000040, 16'h0000, 1'b0);
        finish_req("post_abort_rd");

        // randomized traffic over a small address window so reads hit earlier writes
        for (int i = 0; i < 20; i++) begin
            start_req(1'($urandom_range(0, 1)), 24'($urandom_range(0, 7)) << 4, 16'($urandom), 1'b0);
            finish_req("rnd");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        check("ready_low_while_busy", 48'(ready_bad), 48'd0);
        check("queue_drained", 48'(exp_q.size()), 48'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_sram_ctrl.md
Name: spi_sram_ctrl

Overview:
- SPI master for the external serial SRAM that holds the delay line; sits directly downstream of delay_core's read/write pointer logic.
- Accepts one single-word read or write request at a time and serialises a 48-SCK frame: 8-bit command, 24-bit address, 16-bit data.
- Returns read data, or a write acknowledge, through a one-cycle response strobe.
- Replaces the ad-hoc RAM shifting inside delay_core with a reusable, independently verified stage.

Parameters:
- RAM_NSCK, 48, SCK high pulses per frame (8 cmd + 24 addr + 16 data).
- RAM_CS_LEN, 2, clk cycles css is held low before the first SCK and after the last SCK.
- CMD_READ, 8'h03, SRAM read opcode.
- CMD_WRITE, 8'h02, SRAM write opcode.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  24  word address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle strobe: transaction complete
- rsp_rdata  out  16  read data; valid only while rsp_valid is high
- busy  out  1  high in any state other than IDLE
- sck  out  1  SPI clock to SRAM, idles low (mode 0)
- css  out  1  SRAM chip select, active low
- sdo  out  1  MOSI to SRAM
- sdi  in  1  MISO from SRAM

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: req_ready=0 while rst is asserted, 1 on the first cycle after release; rsp_valid=0, rsp_rdata=0, busy=0, sck=0, css=1, sdo=0.
- All SPI outputs are registered and glitch-free. sck runs at clk/2.
- IDLE: req_ready=1, css=1, sck=0.
  - On req_valid && req_ready, latch frame = {req_we ? CMD_WRITE : CMD_READ, req_addr, req_we ? req_wdata : 16'h0000}, then go to LEAD.
  - Inputs are not required to be stable after the accept edge.
- LEAD: css=0, sdo=frame[47], RAM_CS_LEN cycles, then SHIFT.
- SHIFT: 2*RAM_NSCK cycles alternating sck low/high.
  - On the clk edge that drives sck 0->1, sdi is sampled into a 16-bit rx shift register (MSB first).
  - On the edge that drives sck 1->0, frame shifts left and sdo takes the next bit.
  - After the RAM_NSCK-th high phase, sck returns to 0, go to TRAIL.
- TRAIL: css=0, sck=0, RAM_CS_LEN cycles, then RESP.
- RESP: css=1, rsp_valid=1 for exactly one cycle, req_ready=0.
  - rsp_rdata = rx, i.e. the last 16 sampled bits, for reads; 16'h0000 for writes.
  - Next state is IDLE.
- Latency: rsp_valid asserts 2*RAM_CS_LEN + 2*RAM_NSCK + 1 cycles after the accept edge (101 at defaults). Minimum accept-to-accept spacing is latency + 1 (102).
- req_valid while req_ready=0 is ignored; there is no queueing. Upstream holds req_valid or retries.
- Addresses pass through unchanged; wrap at RAM_END_ADDR is the requester's job.
- rst mid-frame: css goes high and sck low immediately (async); the frame is abandoned with no rsp_valid. The SRAM treats the css rising edge as frame abort.
- rsp_rdata holds its last value after RESP; it is meaningful only with rsp_valid.

Decomposition:
- Package sram_pkg holds:
  - CMD_READ, CMD_WRITE, SRAM_ADDR_W=24, SRAM_DATA_W=16
  - the state enum {IDLE, LEAD, SHIFT, TRAIL, RESP}
- Single module; no sub-module required. The bit counter and phase toggle stay inline.

Test Plan:
- Write: req_we=1, addr=24'h01001C, wdata=16'hA5C3 -> css low for 100 cycles; sdo stream on sck rising edges = 8'h02, 24'h01001C, 16'hA5C3; exactly 48 sck pulses; rsp_valid at accept+101 with rsp_rdata=0.
- Read: addr=24'h000000, bench SRAM model drives 16'h1234 on sdi after the address -> sdo carries 8'h03 and the address; rsp_rdata=16'h1234 on the rsp_valid cycle.
- Read with sdi tied to 1 -> rsp_rdata=16'hFFFF. Back-to-back requests with req_valid held high -> second accept exactly 102 cycles after the first, css high for ≥1 cycle between frames.
- req_valid pulsed during SHIFT -> ignored; no second frame; req_ready stays 0 until IDLE.
- rst asserted at bit 20 of SHIFT -> css=1, sck=0 immediately; no rsp_valid; next request after release produces a complete, correct 48-bit frame.
